// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
// Optional round-robin arbitration is selected with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select between fetch and data requests.
// MEM_ARB_RR_EN: alternate on conflicts using last_grant; otherwise data wins conflicts.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    valid  = i_req | d_req;
    winner = PORT_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_grant == PORT_D) ? PORT_I : PORT_D;
`else
      winner = PORT_D;
`endif
    end else if (d_req) begin
      winner = PORT_D;
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single cache-plus-memory system.
// Define MEM_ARB_RR_EN for round-robin conflict resolution; default is data-port priority.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_Addr,
  input  logic          i_Rd,
  output logic [DW-1:0] i_DataOut,
  output logic          i_Done,
  output logic          i_Stall,
  output logic          i_err,
  input  logic [DW-1:0] d_Addr,
  input  logic [DW-1:0] d_DataIn,
  input  logic          d_Rd,
  input  logic          d_Wr,
  output logic [DW-1:0] d_DataOut,
  output logic          d_Done,
  output logic          d_Stall,
  output logic          d_err,
  output logic          d_CacheHit,
  output logic [DW-1:0] mem_Addr,
  output logic [DW-1:0] mem_DataIn,
  output logic          mem_Rd,
  output logic          mem_Wr,
  input  logic [DW-1:0] mem_DataOut,
  input  logic          mem_Done,
  input  logic          mem_Stall,
  input  logic          mem_CacheHit,
  input  logic          mem_err
);

  state_t        state;
  logic [DW-1:0] req_addr, req_data, rsp_data;
  logic          req_rd, req_wr, req_bad, owner, last_grant;
  logic          rsp_hit, rsp_err, proto_err, i_done_q, d_done_q;
  logic          i_req, d_req, grant_valid, grant_port;

  assign i_req = i_Rd;
  assign d_req = d_Rd | d_Wr;

  mem_arb_grant u_grant (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .valid      (grant_valid),
    .winner     (grant_port)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_data   <= '0;
      req_rd     <= 1'b0;
      req_wr     <= 1'b0;
      req_bad    <= 1'b0;
      owner      <= PORT_I;
      last_grant <= PORT_D;
      rsp_data   <= '0;
      rsp_hit    <= 1'b0;
      rsp_err    <= 1'b0;
      proto_err  <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_Done) proto_err <= 1'b1;
          if (grant_valid) begin
            owner <= grant_port;
            state <= BUSY;
            if (grant_port == PORT_D) begin
              // Rd and Wr together is served as a read and flagged at completion.
              req_addr <= d_Addr;
              req_data <= d_DataIn;
              req_rd   <= d_Rd;
              req_wr   <= d_Wr & ~d_Rd;
              req_bad  <= d_Rd & d_Wr;
            end else begin
              req_addr <= i_Addr;
              req_data <= '0;
              req_rd   <= 1'b1;
              req_wr   <= 1'b0;
              req_bad  <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (mem_Done) begin
            rsp_data   <= mem_DataOut;
            rsp_hit    <= mem_CacheHit;
            rsp_err    <= mem_err | req_bad | proto_err;
            proto_err  <= 1'b0;
            last_grant <= owner;
            req_rd     <= 1'b0;
            req_wr     <= 1'b0;
            i_done_q   <= (owner == PORT_I);
            d_done_q   <= (owner == PORT_D);
            state      <= RESP;
          end
        end
        RESP: begin
          if (mem_Done) proto_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_Addr   = req_addr;
  assign mem_DataIn = req_data;
  assign mem_Rd     = req_rd;
  assign mem_Wr     = req_wr;

  assign i_Done     = i_done_q;
  assign d_Done     = d_done_q;
  assign i_DataOut  = rsp_data;
  assign d_DataOut  = rsp_data;
  assign i_err      = rsp_err;
  assign d_err      = rsp_err;
  assign d_CacheHit = rsp_hit;

  assign i_Stall = i_req & ~i_done_q;
  assign d_Stall = d_req & ~d_done_q;

  // The memory system's own stall is implied by the absence of mem_Done.
  logic unused_mem_stall;
  assign unused_mem_stall = mem_Stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed literal checks.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_Addr, d_Addr, d_DataIn, mem_DataOut;
  logic        i_Rd, d_Rd, d_Wr, mem_Done, mem_Stall, mem_CacheHit, mem_err;
  logic [15:0] i_DataOut, d_DataOut, mem_Addr, mem_DataIn;
  logic        i_Done, i_Stall, i_err, d_Done, d_Stall, d_err, d_CacheHit, mem_Rd, mem_Wr;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_Addr(i_Addr), .i_Rd(i_Rd), .i_DataOut(i_DataOut), .i_Done(i_Done),
    .i_Stall(i_Stall), .i_err(i_err),
    .d_Addr(d_Addr), .d_DataIn(d_DataIn), .d_Rd(d_Rd), .d_Wr(d_Wr),
    .d_DataOut(d_DataOut), .d_Done(d_Done), .d_Stall(d_Stall), .d_err(d_err),
    .d_CacheHit(d_CacheHit),
    .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
    .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
    .mem_CacheHit(mem_CacheHit), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rd;
    logic        wr;
    logic        wiggle;
    logic [15:0] alt;
  } req_t;

  function automatic req_t mk(input logic [15:0] addr, input logic [15:0] data,
                              input logic rd, input logic wr,
                              input logic wiggle, input logic [15:0] alt);
    req_t r;
    r.addr = addr; r.data = data; r.rd = rd; r.wr = wr; r.wiggle = wiggle; r.alt = alt;
    return r;
  endfunction

  req_t i_q[$];
  req_t d_q[$];
  int   i_pres_cyc = 0;
  int   d_pres_cyc = 0;

  // Fetch requester: holds i_Rd until it has seen i_Done, then takes the next queued request.
  initial begin : i_agent
    logic got;
    req_t r;
    i_Rd = 1'b0; i_Addr = '0;
    forever begin
      @(negedge clk); got = i_Done;
      @(posedge clk); #1;
      if (rst || got) i_Rd = 1'b0;
      if (!rst && !i_Rd && i_q.size() > 0) begin
        r = i_q.pop_front();
        i_Addr = r.addr; i_Rd = 1'b1; i_pres_cyc = cyc;
      end
    end
  end

  // Data requester: optionally changes its address while the access is in flight.
  initial begin : d_agent
    logic got, wig;
    logic [15:0] alt;
    req_t r;
    d_Rd = 1'b0; d_Wr = 1'b0; d_Addr = '0; d_DataIn = '0; wig = 1'b0; alt = '0;
    forever begin
      @(negedge clk); got = d_Done;
      @(posedge clk); #1;
      if (rst || got) begin
        d_Rd = 1'b0; d_Wr = 1'b0; wig = 1'b0;
      end else if ((d_Rd || d_Wr) && wig) begin
        d_Addr = alt;
      end
      if (!rst && !d_Rd && !d_Wr && d_q.size() > 0) begin
        r = d_q.pop_front();
        d_Addr = r.addr; d_DataIn = r.data; d_Rd = r.rd; d_Wr = r.wr;
        wig = r.wiggle; alt = r.alt; d_pres_cyc = cyc;
      end
    end
  end

  // Memory system: fixed latency, hit when latency is one cycle; reads of unwritten words return ~addr.
  int          lat = 1;
  logic        spurious_pend = 1'b0;
  logic [15:0] store [logic [15:0]];

  initial begin : responder
    int cnt;
    cnt = 0;
    mem_Done = 1'b0; mem_DataOut = '0; mem_Stall = 1'b0; mem_CacheHit = 1'b0; mem_err = 1'b0;
    forever begin
      @(posedge clk); #2;
      mem_Done = 1'b0; mem_CacheHit = 1'b0; mem_err = 1'b0; mem_Stall = 1'b0;
      if (mem_Rd || mem_Wr) begin
        cnt++;
        if (cnt >= lat) begin
          mem_Done     = 1'b1;
          mem_CacheHit = (lat == 1);
          if (mem_Wr) store[mem_Addr] = mem_DataIn;
          mem_DataOut  = mem_Rd ? (store.exists(mem_Addr) ? store[mem_Addr] : ~mem_Addr) : 16'h0000;
          cnt = 0;
        end else begin
          mem_Stall = 1'b1;
        end
      end else begin
        cnt = 0;
        if (spurious_pend) begin
          mem_Done = 1'b1; mem_DataOut = 16'h1234; spurious_pend = 1'b0;
        end
      end
    end
  end

  // Transaction model: one access in flight; a request is accepted in the first free cycle,
  // memory sees it next cycle, the owner's Done follows mem_Done by one cycle, and the
  // arbiter is free again the cycle after that.
  logic        m_act = 1'b0, m_port = PORT_I, m_rd = 1'b0, m_wr = 1'b0, m_bad = 1'b0;
  logic [15:0] m_addr = '0, m_data = '0;
  int          m_start = 0, free_at = 0, due = -1;
  logic        due_port = PORT_I, due_err = 1'b0, due_hit = 1'b0;
  logic [15:0] due_data = '0;
  logic        lg = PORT_D, sticky = 1'b0;

  // Observations of the DUT for the directed checks.
  logic        done_log[$];
  int          i_done_cyc = 0, d_done_cyc = 0, memdone_cyc = 0, i_stall_cnt = 0;
  logic [15:0] i_last_data = '0, d_last_data = '0, memdone_addr = '0, wr_data = '0, wr_addr = '0;
  logic        i_last_err = 1'b0, d_last_err = 1'b0, d_last_hit = 1'b0, wr_seen = 1'b0;

  initial begin : compare
    int   c;
    logic e_id, e_dd, on_mem, i_want, d_want;
    forever begin
      @(negedge clk);
      c = cyc;
      if (rst) begin
        check1("rst_done", i_Done | d_Done, 1'b0);
        check1("rst_mem_op", mem_Rd | mem_Wr, 1'b0);
        check1("rst_flags", i_err | d_err | d_CacheHit, 1'b0);
        check16("rst_mem_addr", mem_Addr, 16'h0000);
        check16("rst_data_out", i_DataOut | d_DataOut, 16'h0000);
        m_act = 1'b0; due = -1; lg = PORT_D; sticky = 1'b0; free_at = c + 1;
      end else begin
        e_id   = (due == c) && (due_port == PORT_I);
        e_dd   = (due == c) && (due_port == PORT_D);
        on_mem = m_act && (c >= m_start);
        check1("i_done", i_Done, e_id);
        check1("d_done", d_Done, e_dd);
        if (e_id) begin
          check16("i_data", i_DataOut, due_data);
          check1("i_err", i_err, due_err);
        end
        if (e_dd) begin
          check16("d_data", d_DataOut, due_data);
          check1("d_err", d_err, due_err);
          check1("d_hit", d_CacheHit, due_hit);
        end
        check1("mem_rd", mem_Rd, on_mem && m_rd);
        check1("mem_wr", mem_Wr, on_mem && m_wr);
        if (on_mem) check16("mem_addr", mem_Addr, m_addr);
        if (on_mem && m_wr) check16("mem_data_in", mem_DataIn, m_data);
        check1("i_stall", i_Stall, i_Rd & ~e_id);
        check1("d_stall", d_Stall, (d_Rd | d_Wr) & ~e_dd);

        if (mem_Done) begin
          if (on_mem) begin
            due = c + 1; due_port = m_port; due_data = mem_DataOut;
            due_err = mem_err | m_bad | sticky; due_hit = mem_CacheHit;
            sticky = 1'b0; lg = m_port; m_act = 1'b0; free_at = c + 2;
          end else begin
            sticky = 1'b1;
          end
        end
        i_want = i_Rd;
        d_want = d_Rd | d_Wr;
        if (!m_act && c >= free_at && (i_want || d_want)) begin
          if (i_want && d_want) begin
`ifdef MEM_ARB_RR_EN
            m_port = (lg == PORT_D) ? PORT_I : PORT_D;
`else
            m_port = PORT_D;
`endif
          end else begin
            m_port = d_want ? PORT_D : PORT_I;
          end
          if (m_port == PORT_D) begin
            m_addr = d_Addr; m_data = d_DataIn; m_bad = d_Rd & d_Wr;
            m_rd = d_Rd; m_wr = d_Wr & ~d_Rd;
          end else begin
            m_addr = i_Addr; m_data = '0; m_bad = 1'b0; m_rd = 1'b1; m_wr = 1'b0;
          end
          m_start = c + 1; m_act = 1'b1;
        end
      end

      if (i_Done) begin
        done_log.push_back(PORT_I); i_done_cyc = c; i_last_data = i_DataOut; i_last_err = i_err;
      end
      if (d_Done) begin
        done_log.push_back(PORT_D); d_done_cyc = c; d_last_data = d_DataOut;
        d_last_err = d_err; d_last_hit = d_CacheHit;
      end
      if (mem_Done && (mem_Rd || mem_Wr)) begin
        memdone_cyc = c; memdone_addr = mem_Addr;
      end
      if (mem_Wr) begin
        wr_seen = 1'b1; wr_data = mem_DataIn; wr_addr = mem_Addr;
      end
      if (i_Stall) i_stall_cnt++;
    end
  end

  task automatic wait_quiet(input int budget);
    logic settled;
    settled = 1'b0;
    for (int n = 0; n < budget && !settled; n++) begin
      @(negedge clk);
      settled = (i_q.size() == 0) && (d_q.size() == 0) && !i_Rd && !d_Rd && !d_Wr &&
                !m_act && (due < cyc);
    end
    check1("settle", settled, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic exp_order[4];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check1("post_reset_mem_rd", mem_Rd, 1'b0);
    check1("post_reset_i_done", i_Done, 1'b0);

    // Lone fetch, cache hit.
    lat = 1; i_stall_cnt = 0;
    i_q.push_back(mk(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    wait_quiet(40);
    check_int("fetch_latency", i_done_cyc - i_pres_cyc, 2);
    check16("fetch_data", i_last_data, 16'hFFBF);
    check_int("fetch_stall_cycles", i_stall_cnt, 2);

    // Simultaneous fetch and store right after reset.
    do_reset();
    lat = 3; done_log.delete(); wr_seen = 1'b0;
    i_q.push_back(mk(16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    d_q.push_back(mk(16'h0200, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000));
    wait_quiet(60);
    check_int("conflict_count", done_log.size(), 2);
`ifdef MEM_ARB_RR_EN
    check1("conflict_first", done_log[0], PORT_I);
    check1("conflict_second", done_log[1], PORT_D);
`else
    check1("conflict_first", done_log[0], PORT_D);
    check1("conflict_second", done_log[1], PORT_I);
`endif
    check1("store_seen", wr_seen, 1'b1);
    check16("store_data", wr_data, 16'hBEEF);
    check16("store_addr", wr_addr, 16'h0200);

    // Load back the stored word on a hit.
    lat = 1;
    d_q.push_back(mk(16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    wait_quiet(40);
    check16("load_back", d_last_data, 16'hBEEF);
    check1("load_hit", d_last_hit, 1'b1);
    check_int("load_latency", d_done_cyc - d_pres_cyc, 2);

    // Back-to-back conflicts, last grant was the data port.
    lat = 2; done_log.delete();
    i_q.push_back(mk(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    i_q.push_back(mk(16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    d_q.push_back(mk(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    d_q.push_back(mk(16'h0021, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    wait_quiet(80);
`ifdef MEM_ARB_RR_EN
    exp_order[0] = PORT_I; exp_order[1] = PORT_D; exp_order[2] = PORT_I; exp_order[3] = PORT_D;
`else
    exp_order[0] = PORT_D; exp_order[1] = PORT_D; exp_order[2] = PORT_I; exp_order[3] = PORT_I;
`endif
    check_int("b2b_count", done_log.size(), 4);
    for (int k = 0; k < 4 && k < done_log.size(); k++)
      check1($sformatf("b2b_order_%0d", k), done_log[k], exp_order[k]);

    // Ten-cycle miss while the data address changes mid-access.
    lat = 10;
    d_q.push_back(mk(16'h0300, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0ABC));
    wait_quiet(60);
    check16("miss_latched_addr", memdone_addr, 16'h0300);
    check_int("miss_done_delay", d_done_cyc - memdone_cyc, 1);
    check_int("miss_total_latency", d_done_cyc - d_pres_cyc, 11);
    check16("miss_data", d_last_data, 16'hFCFF);
    check1("miss_hit", d_last_hit, 1'b0);

    // Read and write together: served as a read, error flagged.
    lat = 1; wr_seen = 1'b0;
    d_q.push_back(mk(16'h0040, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h0000));
    wait_quiet(40);
    check1("bad_req_err", d_last_err, 1'b1);
    check16("bad_req_data", d_last_data, 16'hFFBF);
    check1("bad_req_no_write", wr_seen, 1'b0);

    // Spurious mem_Done in IDLE is reported on the next completion only.
    spurious_pend = 1'b1;
    repeat (3) @(negedge clk);
    i_q.push_back(mk(16'h0055, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    wait_quiet(40);
    check1("sticky_err", i_last_err, 1'b1);
    check16("sticky_data", i_last_data, 16'hFFAA);
    i_q.push_back(mk(16'h0056, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    wait_quiet(40);
    check1("sticky_cleared", i_last_err, 1'b0);

    // Reset in the middle of a miss, then a normal fetch.
    lat = 10;
    d_q.push_back(mk(16'h0400, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check1("midreset_mem_rd", mem_Rd, 1'b0);
    check1("midreset_d_done", d_Done, 1'b0);
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    check1("after_reset_idle", mem_Rd | mem_Wr, 1'b0);
    lat = 1;
    i_q.push_back(mk(16'h0077, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
    wait_quiet(40);
    check_int("after_reset_latency", i_done_cyc - i_pres_cyc, 2);
    check16("after_reset_data", i_last_data, 16'hFF88);
    check1("after_reset_err", i_last_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
